// File: rtl/mem_io_ctrl.sv
// SRAM / memory-mapped I/O bridge between the SLC-3 datapath and the board.
// A valid/ready request selects one of two I/O registers or an SRAM access
// with a programmable wait-state count. Every accepted request ends with a
// single-cycle Rsp_Valid pulse. All outputs are registered so the SRAM
// strobes are glitch-free.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | Req_Ready high, waiting for a request
// RD     | SRAM read, CE/OE/UB/LB low for WAIT_CYC cycles
// WR     | SRAM write, CE/WE/UB/LB low and bus driven for WAIT_CYC cycles
// WR_REC | WE released, CE low and bus still driven for data hold
// RESP   | Rsp_Valid pulse, all strobes inactive
module mem_io_ctrl #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 20,
    parameter int                WAIT_CYC    = 2,
    parameter logic [ADDR_W-1:0] IO_SW_ADDR  = ADDR_W'(20'h0FFFF),
    parameter logic [ADDR_W-1:0] IO_LED_ADDR = ADDR_W'(20'h0FFFE)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req_Valid,
    output logic              Req_Ready,
    input  logic              Req_We,
    input  logic [ADDR_W-1:0] Req_Addr,
    input  logic [DATA_W-1:0] Req_Wdata,
    output logic              Rsp_Valid,
    output logic [DATA_W-1:0] Rsp_Rdata,
    input  logic [DATA_W-1:0] Switches,
    output logic [DATA_W-1:0] Hex_Out,
    output logic [DATA_W-1:0] LED_Out,
    output logic              Mem_CE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_Wdata,
    input  logic [DATA_W-1:0] Mem_Rdata,
    output logic              Mem_Drive
);

    generate
        if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_bad_wait
            $error("mem_io_ctrl: WAIT_CYC must be within 1..15");
        end
    endgenerate

    localparam int CNT_W = $clog2(WAIT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        WR     = 3'd2,
        WR_REC = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DATA_W-1:0] rsp_rdata_nxt, hex_nxt, led_nxt, wdata_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] sw_meta, sw_sync;
    logic              is_sw, is_led;
    logic              nxt_mem, nxt_drive;

    // Full-width decode: anything not exactly an I/O address is SRAM.
    assign is_sw  = (Req_Addr == IO_SW_ADDR);
    assign is_led = (Req_Addr == IO_LED_ADDR);

    // Strobes for the coming cycle, derived from the next state.
    assign nxt_mem   = (state_nxt == RD) || (state_nxt == WR) || (state_nxt == WR_REC);
    assign nxt_drive = (state_nxt == WR) || (state_nxt == WR_REC);

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state, wait down-counter and register-file update decisions.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rsp_rdata_nxt = Rsp_Rdata;
        hex_nxt       = Hex_Out;
        led_nxt       = LED_Out;
        addr_nxt      = Mem_Addr;
        wdata_nxt     = Mem_Wdata;
        case (state)
            IDLE: begin
                if (Req_Valid) begin
                    addr_nxt  = Req_Addr;
                    wdata_nxt = Req_Wdata;
                    cnt_nxt   = CNT_W'(WAIT_CYC);
                    if (is_sw || is_led) begin
                        state_nxt = RESP;
                        if (Req_We) begin
                            if (is_sw) hex_nxt = Req_Wdata;
                            else       led_nxt = Req_Wdata;
                        end else begin
                            rsp_rdata_nxt = is_sw ? sw_sync : LED_Out;
                        end
                    end else begin
                        state_nxt = Req_We ? WR : RD;
                    end
                end
            end
            RD: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt     = RESP;
                    rsp_rdata_nxt = Mem_Rdata;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            WR: begin
                if (cnt == CNT_W'(1)) state_nxt = WR_REC;
                else                  cnt_nxt   = cnt - CNT_W'(1);
            end
            WR_REC:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs, datapath registers and the switch synchroniser.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt       <= '0;
            Req_Ready <= 1'b1;
            Rsp_Valid <= 1'b0;
            Rsp_Rdata <= '0;
            Hex_Out   <= '0;
            LED_Out   <= '0;
            sw_meta   <= '0;
            sw_sync   <= '0;
            Mem_Addr  <= '0;
            Mem_Wdata <= '0;
            Mem_CE    <= 1'b1;
            Mem_UB    <= 1'b1;
            Mem_LB    <= 1'b1;
            Mem_OE    <= 1'b1;
            Mem_WE    <= 1'b1;
            Mem_Drive <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            Req_Ready <= (state_nxt == IDLE);
            Rsp_Valid <= (state_nxt == RESP);
            Rsp_Rdata <= rsp_rdata_nxt;
            Hex_Out   <= hex_nxt;
            LED_Out   <= led_nxt;
            sw_meta   <= Switches;
            sw_sync   <= sw_meta;
            Mem_Addr  <= addr_nxt;
            Mem_Wdata <= wdata_nxt;
            Mem_CE    <= !nxt_mem;
            Mem_UB    <= !nxt_mem;
            Mem_LB    <= !nxt_mem;
            Mem_OE    <= !(state_nxt == RD);
            Mem_WE    <= !(state_nxt == WR);
            Mem_Drive <= nxt_drive;
        end
    end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed bench for mem_io_ctrl with a small SRAM model and a response
// scoreboard holding the expected Rsp_Rdata of each accepted request.
module tb_mem_io_ctrl;

    logic        Clk, Reset;
    logic        Req_Valid, Req_Ready, Req_We;
    logic [19:0] Req_Addr;
    logic [15:0] Req_Wdata;
    logic        Rsp_Valid;
    logic [15:0] Rsp_Rdata;
    logic [15:0] Switches, Hex_Out, LED_Out;
    logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_Drive;
    logic [19:0] Mem_Addr;
    logic [15:0] Mem_Wdata, Mem_Rdata;

    mem_io_ctrl dut (
        .Clk(Clk), .Reset(Reset),
        .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_We(Req_We),
        .Req_Addr(Req_Addr), .Req_Wdata(Req_Wdata),
        .Rsp_Valid(Rsp_Valid), .Rsp_Rdata(Rsp_Rdata),
        .Switches(Switches), .Hex_Out(Hex_Out), .LED_Out(LED_Out),
        .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE),
        .Mem_WE(Mem_WE), .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata),
        .Mem_Rdata(Mem_Rdata), .Mem_Drive(Mem_Drive)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // SRAM model, aliased on the low address byte.
    logic [15:0] sram [256];
    always @(posedge Clk)
        if (!Mem_CE && !Mem_WE && Mem_Drive) sram[Mem_Addr[7:0]] <= Mem_Wdata;
    assign Mem_Rdata = (!Mem_CE && !Mem_OE) ? sram[Mem_Addr[7:0]] : 16'hDEAD;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q [$];
    logic [15:0] last_rd;
    logic [8:0]  m_ce, m_oe, m_we, m_drv, m_rsp;
    logic [15:0] hex_c1, led_c1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request from cycle 0 (accept) through cycle 8; strobe activity is
    // recorded per cycle and every response is matched against the scoreboard.
    task automatic access(input logic we, input logic [19:0] addr,
                          input logic [15:0] wdata, input string tag);
        Req_We = we; Req_Addr = addr; Req_Wdata = wdata; Req_Valid = 1'b1;
        check({tag, "_ready"}, Req_Ready, 1);
        @(posedge Clk); #1;
        Req_Valid = 1'b0;
        m_ce = '0; m_oe = '0; m_we = '0; m_drv = '0; m_rsp = '0;
        for (int c = 1; c <= 8; c++) begin
            m_ce[c]  = !Mem_CE;
            m_oe[c]  = !Mem_OE;
            m_we[c]  = !Mem_WE;
            m_drv[c] = Mem_Drive;
            m_rsp[c] = Rsp_Valid;
            if (c == 1) begin hex_c1 = Hex_Out; led_c1 = LED_Out; end
            if (Rsp_Valid) begin
                if (exp_q.size() == 0) check({tag, "_extra_rsp"}, 1, 0);
                else check({tag, "_rdata"}, Rsp_Rdata, exp_q.pop_front());
            end
            @(posedge Clk); #1;
        end
        check({tag, "_oe_we_overlap"}, m_oe & m_we, 0);
    endtask

    initial begin
        Reset = 1'b1; Req_Valid = 1'b0; Req_We = 1'b0; Req_Addr = '0;
        Req_Wdata = '0; Switches = '0; last_rd = '0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_ready", Req_Ready, 1);
        check("rst_rsp_valid", Rsp_Valid, 0);
        check("rst_rdata", Rsp_Rdata, 0);
        check("rst_strobes", {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_Drive}, 6'b111110);
        check("rst_hex_led", {Hex_Out, LED_Out}, 0);
        Reset = 1'b0;
        @(posedge Clk); #1;

        // SRAM write, then read back
        exp_q.push_back(last_rd);
        access(1'b1, 20'h00010, 16'h1234, "sram_wr");
        check("sram_wr_we", m_we, 9'b000000110);
        check("sram_wr_drive", m_drv, 9'b000001110);
        check("sram_wr_ce", m_ce, 9'b000001110);
        check("sram_wr_rsp", m_rsp, 9'b000010000);

        last_rd = 16'h1234; exp_q.push_back(last_rd);
        access(1'b0, 20'h00010, 16'h0000, "sram_rd");
        check("sram_rd_oe", m_oe, 9'b000000110);
        check("sram_rd_drive", m_drv, 0);
        check("sram_rd_rsp", m_rsp, 9'b000001000);
        check("rdata_hold", Rsp_Rdata, 16'h1234);

        // Switch read through the synchroniser
        Switches = 16'hA5C3;
        repeat (3) @(posedge Clk);
        #1;
        last_rd = 16'hA5C3; exp_q.push_back(last_rd);
        access(1'b0, 20'h0FFFF, 16'h0000, "sw_rd");
        check("sw_rd_rsp", m_rsp, 9'b000000010);
        check("sw_rd_ce", m_ce, 0);

        // LED register write and read-back
        exp_q.push_back(last_rd);
        access(1'b1, 20'h0FFFE, 16'hBEEF, "led_wr");
        check("led_wr_c1", led_c1, 16'hBEEF);
        check("led_wr_ce", m_ce | m_we | m_oe, 0);
        check("led_wr_rsp", m_rsp, 9'b000000010);

        last_rd = 16'hBEEF; exp_q.push_back(last_rd);
        access(1'b0, 20'h0FFFE, 16'h0000, "led_rd");
        check("led_rd_ce", m_ce | m_oe, 0);

        // Hex register write
        exp_q.push_back(last_rd);
        access(1'b1, 20'h0FFFF, 16'h7E57, "hex_wr");
        check("hex_wr_c1", hex_c1, 16'h7E57);
        check("hex_wr_led_kept", LED_Out, 16'hBEEF);

        // Address that only resembles an I/O address goes to SRAM
        exp_q.push_back(last_rd);
        access(1'b1, 20'h1FFFF, 16'h5A5A, "alias_wr");
        check("alias_wr_we", m_we, 9'b000000110);
        check("alias_wr_regs", {Hex_Out, LED_Out}, {16'h7E57, 16'hBEEF});

        last_rd = 16'h5A5A; exp_q.push_back(last_rd);
        access(1'b0, 20'h1FFFF, 16'h0000, "alias_rd");
        check("alias_rd_oe", m_oe, 9'b000000110);

        // Reset pulse while idle
        Reset = 1'b1; #1;
        check("idle_rst_regs", {Hex_Out, LED_Out}, 0);
        check("idle_rst_strobes", {Req_Ready, Mem_CE, Mem_OE, Mem_WE, Mem_Drive}, 5'b11110);
        @(posedge Clk); #1;
        Reset = 1'b0; last_rd = '0;
        @(posedge Clk); #1;
        check("idle_rst_after", {Req_Ready, Mem_CE, Mem_OE, Mem_WE, Mem_Drive}, 5'b11110);

        // Reset during cycle 1 of an SRAM read, request kept valid
        Req_We = 1'b0; Req_Addr = 20'h00010; Req_Valid = 1'b1;
        @(posedge Clk); #1;
        check("abort_oe_c1", Mem_OE, 0);
        Reset = 1'b1; #1;
        check("abort_oe_now", Mem_OE, 1);
        check("abort_ready", Req_Ready, 1);
        check("abort_rdata", Rsp_Rdata, 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge Clk); #1;
            check("abort_hold", {Mem_OE, Rsp_Valid}, 2'b10);
        end
        #2 Reset = 1'b0;
        @(posedge Clk); #1;
        check("abort_reaccept", {Req_Ready, Mem_OE}, 2'b00);
        Req_Valid = 1'b0;
        last_rd = 16'h1234; exp_q.push_back(last_rd);
        for (int c = 0; c < 10 && !Rsp_Valid; c++) begin
            @(posedge Clk); #1;
        end
        check("abort_retry_rsp", Rsp_Valid, 1);
        if (Rsp_Valid && exp_q.size() != 0)
            check("abort_retry_rdata", Rsp_Rdata, exp_q.pop_front());
        @(posedge Clk); #1;
        check("abort_retry_pulse", Rsp_Valid, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
